matrix_result_reader: RTL and testbench

Read-out side of the matrix multiplier. When the `matrix` datapath signals completion, this block walks the product-matrix result RAM in row-major order through its synchronous read port. It presents each element, tagged with its row and column, on a valid/ready stream toward the testbench checker or a downstream consumer, then pulses `done`.

---
 rtl/matrix_pkg.sv | 21 ++
 rtl/matrix_result_reader_if.sv | 40 ++++
 rtl/matrix_rc_counter.sv | 40 ++++
 rtl/matrix_result_reader.sv | 89 ++++++++
 tb/tb_matrix_result_reader.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared state encodings, default dimensions and index-width helper for the matrix blocks

package matrix_pkg;

  localparam int MATRIX_N  = 4;
  localparam int MATRIX_DW = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_CAPT  = 3'd2;
  localparam state_t ST_SEND  = 3'd3;
  localparam state_t ST_FIN   = 3'd4;

  // A 1x1 matrix still needs one index bit so the ports never collapse to zero width.
  function automatic int rc_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_result_reader_if.sv
// rtl/matrix_result_reader_if.sv - result RAM read port plus element stream between reader and consumer

interface matrix_result_reader_if
  import matrix_pkg::*;
#(
  parameter int N  = MATRIX_N,
  parameter int DW = MATRIX_DW
) ();

  localparam int AW  = $clog2(N * N);
  localparam int RCW = rc_width(N);

  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  rd_data;

  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [RCW-1:0] out_row;
  logic [RCW-1:0] out_col;
  logic           out_last;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output out_valid,
    input  out_ready,
    output out_data, out_row, out_col, out_last
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  out_valid,
    output out_ready,
    input  out_data, out_row, out_col, out_last
  );

endinterface

// File: rtl/matrix_rc_counter.sv
// rtl/matrix_rc_counter.sv - row-major row/column index counter wrapping at N-1, reusable for address sequencing

module matrix_rc_counter
  import matrix_pkg::*;
#(
  parameter  int N   = MATRIX_N,
  localparam int RCW = rc_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           advance,
  output logic [RCW-1:0] row,
  output logic [RCW-1:0] col,
  output logic           last
);

  localparam logic [RCW-1:0] MAX_IDX = RCW'(N - 1);

  assign last = (row == MAX_IDX) && (col == MAX_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      // Stepping past the final element returns both indices to the origin.
      if (col == MAX_IDX) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_result_reader.sv
// rtl/matrix_result_reader.sv - walks the product RAM row-major onto a valid/ready stream, then pulses done
// Optional MATRIX_CHECKSUM_EN adds a running sum of accepted elements on the checksum port.

module matrix_result_reader
  import matrix_pkg::*;
#(
  parameter  int N   = MATRIX_N,
  parameter  int DW  = MATRIX_DW,
  localparam int RCW = rc_width(N),
  localparam int CSW = DW + 2 * RCW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  matrix_result_reader_if.master bus
`ifdef MATRIX_CHECKSUM_EN
  ,
  output logic [CSW-1:0]         checksum
`endif
);

  localparam int AW = $clog2(N * N);

  state_t         state;
  logic [DW-1:0]  data_q;
  logic [RCW-1:0] row;
  logic [RCW-1:0] col;
  logic           last;
  logic           start_ok;
  logic           accept;

  assign start_ok = (state == ST_IDLE) && start;
  assign accept   = (state == ST_SEND) && bus.out_ready;

  matrix_rc_counter #(.N(N)) u_rc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_ok),
    .advance (accept),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      data_q <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (start) state <= ST_FETCH;
        ST_FETCH: state <= ST_CAPT;
        ST_CAPT: begin
          data_q <= bus.rd_data;
          state  <= ST_SEND;
        end
        ST_SEND:  if (bus.out_ready) state <= last ? ST_FIN : ST_FETCH;
        ST_FIN:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Indices only move on acceptance, so a stalled element keeps row/col/last stable.
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_FIN);
  assign bus.rd_en     = (state == ST_FETCH);
  assign bus.rd_addr   = bus.rd_en ? AW'(int'(row) * N + int'(col)) : '0;
  assign bus.out_valid = (state == ST_SEND);
  assign bus.out_data  = data_q;
  assign bus.out_row   = row;
  assign bus.out_col   = col;
  assign bus.out_last  = (state == ST_SEND) && last;

`ifdef MATRIX_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + CSW'(data_q);
    end
  end
`endif

endmodule

// File: tb/tb_matrix_result_reader.sv
// tb/tb_matrix_result_reader.sv - directed bench for matrix_result_reader (N=4), optional MATRIX_CHECKSUM_EN

module tb_matrix_result_reader;
  import matrix_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int CSW = DW + 2 * rc_width(N);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;
`ifdef MATRIX_CHECKSUM_EN
  logic [CSW-1:0] checksum;
`endif

  matrix_result_reader_if #(.N(N), .DW(DW)) bus ();

  matrix_result_reader #(.N(N), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
`ifdef MATRIX_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [N*N];

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_rd_en"}, bus.rd_en, 0);
    check({tag, "_addr"},  bus.rd_addr, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_data"},  bus.out_data, 0);
    check({tag, "_row"},   bus.out_row, 0);
    check({tag, "_col"},   bus.out_col, 0);
    check({tag, "_last"},  bus.out_last, 0);
    check({tag, "_done"},  done, 0);
`ifdef MATRIX_CHECKSUM_EN
    check({tag, "_cksum"}, checksum, 0);
`endif
  endtask

  // Runs one transfer starting at a negedge; cycle 1 is the cycle after start is sampled.
  task automatic run_xfer(input int stall_k, input int stall_len, input int poke_k,
                          input bit poke_done, input int exp_done);
    int k, cyc, held, done_cyc, first_valid, extra;
    bit poked;
    logic [31:0] s_data, s_row, s_col, s_last;
    k = 0; held = 0; done_cyc = -1; first_valid = -1; extra = 0; poked = 0;
    s_data = 0; s_row = 0; s_col = 0; s_last = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("c1_rd_en", bus.rd_en, 1);
    check("c1_addr", bus.rd_addr, 0);
    check("c1_busy", busy, 1);
`ifdef MATRIX_CHECKSUM_EN
    check("c1_cksum_clr", checksum, 0);
`endif
    for (int t = 0; t < 400 && done_cyc < 0; t++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      bus.out_ready = 1'b1;
      if (done) begin
        done_cyc = cyc;
        check("done_busy", busy, 1);
`ifdef MATRIX_CHECKSUM_EN
        check("done_cksum", checksum, 408);
`endif
        if (poke_done) start = 1'b1;
      end
      if (bus.out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (k == poke_k && !poked) begin
          start = 1'b1;
          poked = 1'b1;
        end
        if (k == stall_k && held < stall_len) begin
          if (held == 0) begin
            s_data = bus.out_data; s_row = bus.out_row;
            s_col  = bus.out_col;  s_last = bus.out_last;
          end else begin
            check("hold_data", bus.out_data, s_data);
            check("hold_row", bus.out_row, s_row);
            check("hold_col", bus.out_col, s_col);
            check("hold_last", bus.out_last, s_last);
            check("hold_valid", bus.out_valid, 1);
          end
          check("hold_rd_en", bus.rd_en, 0);
          bus.out_ready = 1'b0;
          held++;
        end else if (k < N * N) begin
          check("elem_row", bus.out_row, k / N);
          check("elem_col", bus.out_col, k % N);
          check("elem_data", bus.out_data, 16 * (k / N) + (k % N));
          check("elem_last", bus.out_last, (k == N * N - 1) ? 1 : 0);
          k++;
        end else begin
          extra++;
        end
      end
    end
    check("first_valid_cyc", first_valid, 3);
    check("elem_count", k, N * N);
    check("extra_elems", extra, 0);
    check("done_cyc", done_cyc, exp_done);
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("busy_fall", busy, 0);
`ifdef MATRIX_CHECKSUM_EN
    check("cksum_stable", checksum, 408);
`endif
    extra = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (busy || bus.rd_en || bus.out_valid || done) extra++;
    end
    check("post_idle_activity", extra, 0);
  endtask

  initial begin
    int act;
    bit found;
    for (int a = 0; a < N * N; a++) mem[a] = DW'(16 * (a / N) + (a % N));
    bus.out_ready = 1'b1;

    repeat (5) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    act = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (busy || bus.rd_en || bus.out_valid || done) act++;
    end
    check("idle_activity", act, 0);

    run_xfer(-1, 0, -1, 1'b0, 49);
    run_xfer(6, 7, -1, 1'b0, 56);
    run_xfer(-1, 0, 8, 1'b1, 49);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_row == 1 && bus.out_col == 1) found = 1'b1;
    end
    check("reach_1_1", found, 1);
    check("pre_rst_data", bus.out_data, 17);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_idle", busy, 0);
    run_xfer(-1, 0, -1, 1'b0, 49);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
